comparator_serial: RTL and testbench
====================================

// Module: comparator_serial
// PURPOSE
//  Parametrised magnitude comparator: compares two WIDTH-bit operands MSB-first, CHUNK bits per clock,
//  with early exit on the first differing chunk. Signed or unsigned per transaction.
//  Valid/ready on input and output. Serves wide datapaths where a flat WIDTH-bit compare misses timing.
//  Outputs Y0 (A<B), Y1 (A==B), Y2 (A>B), one-hot when valid.
// PARAMETERS
//  WIDTH  32  operand width in bits; must be a multiple of CHUNK, >= CHUNK
//  CHUNK  4   bits compared per cycle; NCHUNK = WIDTH/CHUNK (derived localparam)
// PORTS
//  clk          in   1      single clock; all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      A, B, signed_mode valid
//  in_ready     out  1      block can accept an operand pair
//  A            in   WIDTH  operand A
//  B            in   WIDTH  operand B
//  signed_mode  in   1      1: two's-complement compare; 0: unsigned
//  out_valid    out  1      Y0/Y1/Y2 hold a result
//  out_ready    in   1      consumer takes the result
//  Y0           out  1      A < B
//  Y1           out  1      A == B
//  Y2           out  1      A > B
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, cnt=0, shift regs=0, out_valid=0, Y0=Y1=Y2=0, in_ready=1.
//  in_ready = (state==IDLE), decoded from state. No input skid; one transaction in flight.
//  FSM IDLE -> CMP -> DONE -> IDLE.
//   IDLE: on in_valid&&in_ready, load A/B into shift regs, cnt<=0, go CMP. In signed mode invert
//     the MSB of both operands at load (offset-binary), so CMP is always unsigned.
//   CMP: compare top CHUNK bits of both regs. Differ: latch lt/gt into Y0/Y2, Y1=0, go DONE.
//     Equal and cnt==NCHUNK-1: Y1=1, Y0=Y2=0, go DONE. Otherwise shift both regs left CHUNK, cnt++.
//   DONE: out_valid=1, Y* held stable. On out_ready go IDLE, out_valid=0 and Y* cleared to 0
//     on the same edge. in_ready rises the cycle after the handshake.
//  Latency: accept at edge t0; out_valid high after edge t0+k, k = 1-based index of first differing
//   chunk from MSB. Equal operands: k=NCHUNK. Throughput: at most one result every k+2 cycles.
//  in_valid while busy: ignored (in_ready=0); the source must hold its data.
//  out_ready while out_valid=0: no effect. Y0/Y1/Y2 are 0 whenever out_valid=0.
//  Operands sampled only at accept; later changes on A/B/signed_mode do not affect the result.
//  Reset mid-transaction: result discarded, no out_valid pulse, all outputs return to reset values.
//  cnt width = max(1,$clog2(NCHUNK)); cnt never exceeds NCHUNK-1 (no wrap).
// STRUCTURE
//  Shared package comparator_pkg: FSM state encodings (IDLE/CMP/DONE) and a clog2 helper.
//  One sub-module: chunk_compare, a parametrised CHUNK-bit combinational compare giving lt/eq/gt.
//   Instantiated once on the shift-reg heads.
//  Top level holds the FSM, chunk counter, operand shift regs and result regs.
// TESTING (bench WIDTH=8, CHUNK=4 unless noted)
//  1. Reset: rst_n=0 mid-CMP with A=8'h12,B=8'h13 -> in_ready=1, out_valid=0, Y*=0 immediately;
//     no result after release.
//  2. Early exit, unsigned: A=8'h52,B=8'h31 -> Y2=1, out_valid after 1 edge (k=1).
//     A=8'h35,B=8'h37 -> Y0=1, k=2.
//  3. Equal: A=B=8'hA5 -> Y1=1 after NCHUNK=2 edges.
//     WIDTH=32: A=B=32'hDEADBEEF -> Y1=1 after 8 edges.
//  4. Signed: signed_mode=1, A=8'h80(-128), B=8'h01 -> Y0=1.
//     Same operands with signed_mode=0 -> Y2=1.
//  5. Backpressure: hold out_ready=0 for 5 cycles -> out_valid and Y* stable, in_ready=0,
//     second in_valid ignored. out_ready=1 -> IDLE next edge, then second pair accepted.
//  6. Random: 10k random A/B/signed_mode with random out_ready -> every result matches the
//     reference $signed/unsigned compare; Y* one-hot when out_valid=1.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encodings and a
// counter-width helper.
package comparator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one CHUNK-wide slice; exactly one output is high.
module chunk_compare #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         lt_o,
   output logic         eq_o,
   output logic         gt_o
);

   assign lt_o = (a_i <  b_i);
   assign eq_o = (a_i == b_i);
   assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/comparator_serial.sv
// MSB-first serial magnitude comparator, CHUNK bits per cycle with early exit on
// the first differing chunk; signed operands are mapped to offset-binary at load.
module comparator_serial
   import comparator_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             Y0,
   output logic             Y1,
   output logic             Y2
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = clog2_min1(NCHUNK);
   localparam logic [CW-1:0]    LAST     = CW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       y_q, y_d;   // {gt, eq, lt}
   logic             lt, eq, gt;

   chunk_compare #(.W(CHUNK)) u_chunk_compare (
      .a_i  (a_q[WIDTH-1 -: CHUNK]),
      .b_i  (b_q[WIDTH-1 -: CHUNK]),
      .lt_o (lt),
      .eq_o (eq),
      .gt_o (gt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               // Flipping both MSBs turns a signed compare into an unsigned one.
               a_d     = signed_mode ? (A ^ MSB_MASK) : A;
               b_d     = signed_mode ? (B ^ MSB_MASK) : B;
               cnt_d   = '0;
               state_d = ST_CMP;
            end
         end
         ST_CMP: begin
            if (!eq) begin
               y_d     = {gt, 1'b0, lt};
               state_d = ST_DONE;
            end else if (cnt_q == LAST) begin
               y_d     = 3'b010;
               state_d = ST_DONE;
            end else begin
               a_d   = a_q << CHUNK;
               b_d   = b_q << CHUNK;
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               y_d     = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign Y0        = y_q[0];
   assign Y1        = y_q[1];
   assign Y2        = y_q[2];

endmodule

// File: tb/tb_comparator_serial.sv
// Bench for comparator_serial: cycle-level reference model plus directed and random vectors.
module tb_comparator_serial;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int NC = W / C;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b0, signed_mode = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic         in_ready, out_valid, Y0, Y1, Y2;

   logic         in_valid32 = 1'b0, out_ready32 = 1'b0;
   logic [31:0]  A32 = '0, B32 = '0;
   logic         in_ready32, out_valid32, Y0_32, Y1_32, Y2_32;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   comparator_serial #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .Y0(Y0), .Y1(Y1), .Y2(Y2)
   );

   comparator_serial #(.WIDTH(32), .CHUNK(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .A(A32), .B(B32), .signed_mode(1'b0), .out_valid(out_valid32),
      .out_ready(out_ready32), .Y0(Y0_32), .Y1(Y1_32), .Y2(Y2_32)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result {gt, eq, lt} straight from the language's own compares.
   function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      if (s) return {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
      return {a > b, a == b, a < b};
   endfunction

   // Edges from accept to result: 1-based index of first differing chunk from MSB.
   function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = 0; i < NC; i++)
         if (a[W-1-i*C -: C] != b[W-1-i*C -: C]) return i + 1;
      return NC;
   endfunction

   // Transaction-level model: busy from accept to handshake, result visible after k edges.
   logic       m_busy = 1'b0, m_valid = 1'b0;
   int         m_wait = 0;
   logic [2:0] m_exp = '0;
   int         n_acc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_wait  <= 0;
         m_exp   <= '0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy <= 1'b1;
            m_wait <= ref_lat(A, B);
            m_exp  <= ref_cmp(A, B, signed_mode);
            n_acc  <= n_acc + 1;
         end
      end else if (!m_valid) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) m_valid <= 1'b1;
      end else if (out_ready) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("mdl_in_ready", in_ready, !m_busy);
      chk("mdl_out_valid", out_valid, m_valid);
      chk("mdl_y", {Y2, Y1, Y0}, m_valid ? m_exp : 3'b000);
   end

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // Accept one pair, scramble the inputs, check latency and result against literals.
   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [2:0] ey, input int ek, input string nm);
      int n;
      @(posedge clk); #1;
      A = a; B = b; signed_mode = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; A = ~a; B = ~b; signed_mode = ~s;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_lat"}, n, ek);
      chk({nm, "_y"}, {Y2, Y1, Y0}, ey);
      ack();
   endtask

   initial begin
      int n, acc0, cyc;

      chk("pin_lat_52_31", ref_lat(8'h52, 8'h31), 1);
      chk("pin_lat_35_37", ref_lat(8'h35, 8'h37), 2);
      chk("pin_cmp_s", ref_cmp(8'h80, 8'h01, 1'b1), 3'b001);
      chk("pin_cmp_u", ref_cmp(8'h80, 8'h01, 1'b0), 3'b100);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", {Y2, Y1, Y0}, 0);
      chk("rst_in_ready32", in_ready32, 1);

      // Reset while comparing: everything returns to idle and no result appears.
      @(posedge clk); #1;
      A = 8'h12; B = 8'h13; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("midcmp_busy", in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_y", {Y2, Y1, Y0}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("postrst_no_result", out_valid, 0);
      end

      run(8'h52, 8'h31, 1'b0, 3'b100, 1, "gt_k1");
      run(8'h35, 8'h37, 1'b0, 3'b001, 2, "lt_k2");
      run(8'hA5, 8'hA5, 1'b0, 3'b010, 2, "eq");
      run(8'h80, 8'h01, 1'b1, 3'b001, 1, "signed_lt");
      run(8'h80, 8'h01, 1'b0, 3'b100, 1, "unsigned_gt");
      run(8'hFF, 8'h7F, 1'b1, 3'b001, 1, "signed_neg1");

      // Equal 32-bit operands walk all 8 chunks.
      @(posedge clk); #1;
      A32 = 32'hDEADBEEF; B32 = 32'hDEADBEEF; in_valid32 = 1'b1;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      n = 0;
      while (!out_valid32 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("eq32_lat", n, 8);
      chk("eq32_y", {Y2_32, Y1_32, Y0_32}, 3'b010);
      out_ready32 = 1'b1;
      @(posedge clk); #1;
      out_ready32 = 1'b0;
      chk("eq32_cleared", {out_valid32, Y2_32, Y1_32, Y0_32}, 0);

      // Backpressure: result held while a second pair waits on in_valid.
      @(posedge clk); #1;
      A = 8'h52; B = 8'h31; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      A = 8'h01; B = 8'h02;
      @(posedge clk); #1;
      repeat (5) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_y", {Y2, Y1, Y0}, 3'b100);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      ack();
      chk("bp_idle", in_ready, 1);
      chk("bp_y_cleared", {out_valid, Y2, Y1, Y0}, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_accepted", in_ready, 0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_second_lat", n, 2);
      chk("bp_second_y", {Y2, Y1, Y0}, 3'b001);
      ack();

      // Random traffic with biased equal / equal-top-chunk operands; model checks each cycle.
      acc0 = n_acc;
      cyc  = 0;
      while ((n_acc - acc0) < 10000 && cyc < 80000) begin
         @(posedge clk); #1;
         cyc++;
         in_valid    = ($urandom_range(0, 3) != 0);
         A           = 8'($urandom);
         signed_mode = 1'($urandom);
         out_ready   = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       B = A;
            1:       B = {A[7:4], 4'($urandom)};
            default: B = 8'($urandom);
         endcase
      end
      chk("rand_count_reached", (n_acc - acc0) >= 10000, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
